// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b computed one bit per clock over WIDTH cycles.
// A single borrow flop carries the borrow between bit positions; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] sr_n;

  // Full-subtractor cell applied to the current LSBs.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_n   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign sr_n   = {d, sr[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        // New operands may be taken in the completion cycle, so no idle gap is needed.
        if (start) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_n;
      br  <= br_n;
      cnt <= cnt + 1'b1;
      // Results only move on completion; they hold across the next operation.
      if (last) begin
        diff       <= sr_n;
        borrow_out <= br_n;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed table-driven bench for serial_subtractor (WIDTH=4), plus back-to-back,
// mid-operation reset and exhaustive operand sweeps.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] held_diff = '0;
  logic         held_br   = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         br;
  } vec_t;

  vec_t vecs[10];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One operation with start pulsed for a single edge; operands scrambled during SHIFT.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input string nm);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = (k == 2);  // ignored while busy
      a = W'($urandom);
      b = W'($urandom);
      chk({nm, ".busy"}, 32'(busy), 32'd1);
      chk({nm, ".done_lo"}, 32'(done), 32'd0);
      chk({nm, ".held"}, 32'({held_br, held_diff}), 32'({borrow_out, diff}));
    end
    start = 1'b0;
    @(negedge clk);
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".busy_lo"}, 32'(busy), 32'd0);
    chk({nm, ".diff"}, 32'(diff), 32'(ed));
    chk({nm, ".borrow"}, 32'(borrow_out), 32'(eb));
    held_diff = ed; held_br = eb;
    @(negedge clk);
    chk({nm, ".pulse"}, 32'(done), 32'd0);
    chk({nm, ".stable"}, 32'({borrow_out, diff}), 32'({held_br, held_diff}));
  endtask

  initial begin
    vecs[0] = '{4'd7,  4'd3,  4'h4, 1'b0};
    vecs[1] = '{4'd3,  4'd7,  4'hC, 1'b1};
    vecs[2] = '{4'd0,  4'd1,  4'hF, 1'b1};
    vecs[3] = '{4'd15, 4'd15, 4'h0, 1'b0};
    vecs[4] = '{4'd0,  4'd0,  4'h0, 1'b0};
    vecs[5] = '{4'd8,  4'd1,  4'h7, 1'b0};
    vecs[6] = '{4'd1,  4'd8,  4'h9, 1'b1};
    vecs[7] = '{4'd15, 4'd0,  4'hF, 1'b0};
    vecs[8] = '{4'd0,  4'd15, 4'h1, 1'b1};
    vecs[9] = '{4'd10, 4'd5,  4'h5, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].br, $sformatf("vec%0d", i));

    // Back-to-back: start held high, next operands presented only in the DONE cycle.
    @(negedge clk);
    a = 4'd12; b = 4'd5; start = 1'b1;
    begin
      logic [W-1:0] opa[4] = '{4'd12, 4'd2, 4'd9, 4'd6};
      logic [W-1:0] opb[4] = '{4'd5,  4'd11, 4'd9, 4'd1};
      for (int i = 0; i < 4; i++) begin
        for (int k = 1; k <= W + 1; k++) begin
          @(negedge clk);
          if (k <= W) begin
            chk($sformatf("b2b%0d.busy", i), 32'(busy), 32'd1);
            a = W'($urandom); b = W'($urandom);
          end else begin
            chk($sformatf("b2b%0d.done", i), 32'(done), 32'd1);
            chk($sformatf("b2b%0d.diff", i), 32'(diff), 32'(W'(opa[i] - opb[i])));
            chk($sformatf("b2b%0d.borrow", i), 32'(borrow_out), 32'(opa[i] < opb[i]));
            held_diff = W'(opa[i] - opb[i]); held_br = (opa[i] < opb[i]);
            if (i < 3) begin a = opa[i+1]; b = opb[i+1]; end
            else start = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    chk("b2b.end_idle", 32'({busy, done}), 32'd0);

    // Reset two cycles into an operation.
    a = 4'd9; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.diff", 32'(diff), 32'd0);
    chk("mrst.borrow", 32'(borrow_out), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst.no_done", 32'({busy, done}), 32'd0);
    end
    rst = 1'b0;
    held_diff = '0; held_br = 1'b0;
    repeat (W + 1) begin
      @(negedge clk);
      chk("post_rst.no_done", 32'({busy, done}), 32'd0);
    end
    run_op(4'd9, 4'd2, 4'h7, 1'b0, "post_rst");

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        run_op(W'(ai), W'(bi), W'(ai - bi), (ai < bi), $sformatf("sw_%0d_%0d", ai, bi));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
